// File: rtl/hp_pkg.sv
// rtl/hp_pkg.sv - shared constants for the wb_hp_multi glitch-detector peripheral
//
// Purpose: register word offsets (byte offset >> 2), CTRL bit positions,
//          INFO magic and the upper limits for channel count / counter width.
// Ports:   none (package).
`timescale 1ns/10ps
package hp_pkg;

   localparam int MAX_N_CH  = 16;
   localparam int MAX_CNT_W = 16;

   // Word offsets, compared against i_wb_addr[7:2]
   localparam logic [5:0] OFF_CTRL  = 6'h00;
   localparam logic [5:0] OFF_LATCH = 6'h01;
   localparam logic [5:0] OFF_MASK  = 6'h02;
   localparam logic [5:0] OFF_OVF   = 6'h03;
   localparam logic [5:0] OFF_INFO  = 6'h04;
   localparam logic [5:0] OFF_CNT0  = 6'h08;

   localparam int CTRL_VCC    = 0;
   localparam int CTRL_EN     = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_WRAP   = 3;

   localparam logic [15:0] INFO_MAGIC = 16'h4850;

endpackage

// File: rtl/hp_glitch_chan.sv
// rtl/hp_glitch_chan.sv - one glitch-capture channel: toggle, synchroniser, latch, counter
//
// Purpose: captures rising edges on an asynchronous glitch input by toggling a
//          flop clocked by the glitch itself, brings the toggle into clk and
//          turns each change into a one-cycle event feeding latch/counter/OVF.
// Ports:   clk, reset (async, active-low), glitch_i (async),
//          en_i / wrap_i (CTRL bits), latch_clr_i / ctr_clr_i / ovf_clr_i (clears),
//          latch_o, ovf_o, cnt_o, alarm_async_o (toggle vs. prev mismatch).
`timescale 1ns/10ps
module hp_glitch_chan #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             glitch_i,
   input  logic             en_i,
   input  logic             wrap_i,
   input  logic             latch_clr_i,
   input  logic             ctr_clr_i,
   input  logic             ovf_clr_i,
   output logic             latch_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             alarm_async_o
);
   import hp_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                   toggle_q, toggle_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   latch_q, latch_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   evt;
   logic [CNT_W-1:0]       cnt_base;

   always_comb toggle_d = ~toggle_q;

   // Clocked by the glitch itself so pulses shorter than a clk period are seen
   always_ff @(posedge glitch_i or negedge reset) begin
      if (!reset) toggle_q <= 1'b0;
      else        toggle_q <= toggle_d;
   end

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], toggle_q};
      prev_d   = sync_q[SYNC_STAGES-1];
      evt      = en_i & (sync_q[SYNC_STAGES-1] ^ prev_q);
      // A clear and an event in the same cycle: the event is applied on top of
      // the cleared value so it is never lost.
      latch_d  = (latch_clr_i ? 1'b0 : latch_q) | evt;
      cnt_base = ctr_clr_i ? '0 : cnt_q;
      ovf_d    = ovf_clr_i ? 1'b0 : ovf_q;
      cnt_d    = cnt_base;
      if (evt) begin
         if (cnt_base != CNT_MAX) begin
            cnt_d = cnt_base + 1'b1;
         end else if (wrap_i) begin
            cnt_d = '0;
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         latch_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         latch_q <= latch_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign latch_o       = latch_q;
   assign ovf_o         = ovf_q;
   assign cnt_o         = cnt_q;
   // Raw mismatch: rises on the glitch edge, clears once prev_q catches up
   assign alarm_async_o = toggle_q ^ prev_q;

endmodule

// File: rtl/wb_hp_multi.sv
// rtl/wb_hp_multi.sv - multi-channel glitch detector with Wishbone register access
//
// Purpose: Wishbone decode, CTRL/MASK registers, clear synchronisers, read mux,
//          irq generation and N_CH hp_glitch_chan instances.
// Ports:   clk, reset (async, active-low); Wishbone i_wb_cyc/stb/we/addr/data,
//          o_wb_ack/stall/data; glitch_i[N_CH]; ext_latch_clr, ext_ctr_clr;
//          hp_vcc_o, alarm_o[N_CH], alarm_async_o[N_CH], irq_o.
`timescale 1ns/10ps
module wb_hp_multi #(
   parameter int          N_CH        = 4,
   parameter int          CNT_W       = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   input  logic            i_wb_we,
   input  logic [31:0]     i_wb_addr,
   input  logic [31:0]     i_wb_data,
   output logic            o_wb_ack,
   output logic            o_wb_stall,
   output logic [31:0]     o_wb_data,
   input  logic [N_CH-1:0] glitch_i,
   input  logic            ext_latch_clr,
   input  logic            ext_ctr_clr,
   output logic            hp_vcc_o,
   output logic [N_CH-1:0] alarm_o,
   output logic [N_CH-1:0] alarm_async_o,
   output logic            irq_o
);
   import hp_pkg::*;

   logic            ack_q, ack_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [3:0]      ctrl_q, ctrl_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic [1:0]      lclr_sync_q, lclr_sync_d;
   logic [1:0]      cclr_sync_q, cclr_sync_d;
   logic            irq_q, irq_d;

   logic [5:0]      off;
   logic            hit, req, wr;
   logic [N_CH-1:0] latch, ovf, latch_clr, ctr_clr, ovf_clr;
   logic [CNT_W-1:0] cnt_w [N_CH];
   logic            unused_bits;

   assign off         = i_wb_addr[7:2];
   assign hit         = (i_wb_addr[31:8] == BASE_ADDR[31:8]);
   assign unused_bits = ^{i_wb_addr[1:0], i_wb_data};

   always_comb begin
      req         = i_wb_cyc & i_wb_stb;
      wr          = req & i_wb_we & hit;
      ack_d       = req;
      lclr_sync_d = {lclr_sync_q[0], ext_latch_clr};
      cclr_sync_d = {cclr_sync_q[0], ext_ctr_clr};

      ctrl_d = ctrl_q;
      if (wr && off == OFF_CTRL) ctrl_d = i_wb_data[3:0];
      mask_d = mask_q;
      if (wr && off == OFF_MASK) mask_d = i_wb_data[N_CH-1:0];

      latch_clr = {N_CH{lclr_sync_q[1]}};
      if (wr && off == OFF_LATCH) latch_clr = latch_clr | i_wb_data[N_CH-1:0];
      ovf_clr = (wr && off == OFF_OVF) ? i_wb_data[N_CH-1:0] : '0;
      for (int c = 0; c < N_CH; c++)
         ctr_clr[c] = cclr_sync_q[1] | (wr && off == OFF_CNT0 + 6'(c));

      irq_d = (|(latch & mask_q)) & ctrl_q[CTRL_IRQ_EN];

      // Only mapped reads inside our window return data; everything else is 0
      rdata_d = '0;
      if (req && !i_wb_we && hit) begin
         case (off)
            OFF_CTRL:  rdata_d = 32'(ctrl_q);
            OFF_LATCH: rdata_d = 32'(MAX_N_CH'(latch));
            OFF_MASK:  rdata_d = 32'(MAX_N_CH'(mask_q));
            OFF_OVF:   rdata_d = 32'(MAX_N_CH'(ovf));
            OFF_INFO:  rdata_d = {INFO_MAGIC, 8'(CNT_W), 8'(N_CH)};
            default: begin
               for (int c = 0; c < N_CH; c++)
                  if (off == OFF_CNT0 + 6'(c)) rdata_d = 32'(MAX_CNT_W'(cnt_w[c]));
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         ctrl_q      <= '0;
         mask_q      <= '0;
         lclr_sync_q <= '0;
         cclr_sync_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         ctrl_q      <= ctrl_d;
         mask_q      <= mask_d;
         lclr_sync_q <= lclr_sync_d;
         cclr_sync_q <= cclr_sync_d;
         irq_q       <= irq_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      hp_glitch_chan #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .glitch_i      (glitch_i[g]),
         .en_i          (ctrl_q[CTRL_EN]),
         .wrap_i        (ctrl_q[CTRL_WRAP]),
         .latch_clr_i   (latch_clr[g]),
         .ctr_clr_i     (ctr_clr[g]),
         .ovf_clr_i     (ovf_clr[g]),
         .latch_o       (latch[g]),
         .ovf_o         (ovf[g]),
         .cnt_o         (cnt_w[g]),
         .alarm_async_o (alarm_async_o[g])
      );
   end

   assign o_wb_ack   = ack_q;
   assign o_wb_stall = 1'b0;
   assign o_wb_data  = rdata_q;
   assign hp_vcc_o   = ctrl_q[CTRL_VCC];
   assign alarm_o    = latch;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_hp_multi.sv
// tb/tb_wb_hp_multi.sv - directed self-checking bench for wb_hp_multi
`timescale 1ns/10ps
module tb_wb_hp_multi;

   localparam logic [31:0] BASE    = 32'h3000_0000;
   localparam logic [31:0] A_CTRL  = BASE + 32'h00;
   localparam logic [31:0] A_LATCH = BASE + 32'h04;
   localparam logic [31:0] A_MASK  = BASE + 32'h08;
   localparam logic [31:0] A_OVF   = BASE + 32'h0C;
   localparam logic [31:0] A_INFO  = BASE + 32'h10;
   localparam logic [31:0] A_CNT0  = BASE + 32'h20;
   localparam logic [31:0] A_CNT1  = BASE + 32'h24;
   localparam logic [31:0] A_CNT2  = BASE + 32'h28;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
   logic [31:0] i_wb_addr = '0, i_wb_data = '0;
   logic        o_wb_ack, o_wb_stall;
   logic [31:0] o_wb_data;
   logic [3:0]  glitch_i = '0;
   logic        ext_latch_clr = 1'b0, ext_ctr_clr = 1'b0;
   logic        hp_vcc_o, irq_o;
   logic [3:0]  alarm_o, alarm_async_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   wb_hp_multi #(
      .N_CH(4), .CNT_W(8), .SYNC_STAGES(2), .BASE_ADDR(32'h3000_0000)
   ) dut (
      .clk(clk), .reset(reset),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
      .glitch_i(glitch_i), .ext_latch_clr(ext_latch_clr), .ext_ctr_clr(ext_ctr_clr),
      .hp_vcc_o(hp_vcc_o), .alarm_o(alarm_o), .alarm_async_o(alarm_async_o),
      .irq_o(irq_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
      i_wb_addr = addr; i_wb_data = data;
      tick();
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
      i_wb_addr = addr;
      tick();
      check_eq("rd_ack", {31'b0, o_wb_ack}, 32'd1);
      data = o_wb_data;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
   endtask

   task automatic glitch(input int c);
      glitch_i[c] = 1'b1;
      #0.1;
      glitch_i[c] = 1'b0;
   endtask

   initial begin
      int sp[8];
      sp = '{3, 5, 19, 4, 7, 3, 11, 6};

      // Reset state
      #100;
      check_eq("rst_ack", {31'b0, o_wb_ack}, 32'd0);
      check_eq("rst_data", o_wb_data, 32'd0);
      check_eq("rst_vcc", {31'b0, hp_vcc_o}, 32'd0);
      check_eq("rst_alarm", {28'b0, alarm_o}, 32'd0);
      check_eq("rst_alarm_async", {28'b0, alarm_async_o}, 32'd0);
      check_eq("rst_irq", {31'b0, irq_o}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      tick();
      wb_read(A_INFO, rd);  check_eq("info", rd, 32'h4850_0804);

      // CTRL write, back-to-back reads, address mismatch, unmapped offset
      wb_write(A_CTRL, 32'h3);
      check_eq("vcc_on", {31'b0, hp_vcc_o}, 32'd1);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = A_INFO;
      tick();
      check_eq("b2b_ack0", {31'b0, o_wb_ack}, 32'd1);
      check_eq("b2b_data0", o_wb_data, 32'h4850_0804);
      i_wb_addr = A_CTRL;
      tick();
      check_eq("b2b_ack1", {31'b0, o_wb_ack}, 32'd1);
      check_eq("b2b_data1", o_wb_data, 32'h3);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      tick();
      check_eq("ack_drop", {31'b0, o_wb_ack}, 32'd0);
      wb_write(32'h4000_0000, 32'hF);
      wb_read(A_CTRL, rd);  check_eq("miss_wr_ignored", rd, 32'h3);
      wb_read(32'h4000_0010, rd);  check_eq("miss_rd_zero", rd, 32'd0);
      wb_read(BASE + 32'h14, rd);  check_eq("unmapped_rd", rd, 32'd0);

      // Burst of 8 short pulses on channel 0
      for (int i = 0; i < 8; i++) begin
         glitch(0);
         check_eq("async_rise", {28'b0, alarm_async_o}, 32'h1);
         repeat (2) tick();
         check_eq("async_hold", {28'b0, alarm_async_o}, 32'h1);
         tick();
         check_eq("async_fall", {28'b0, alarm_async_o}, 32'h0);
         repeat (sp[i] - 3) tick();
      end
      repeat (4) tick();
      wb_read(A_CNT0, rd);  check_eq("cnt0_burst", rd, 32'd8);
      wb_read(A_LATCH, rd); check_eq("latch_burst", rd, 32'h1);
      wb_read(A_CNT1, rd);  check_eq("cnt1_idle", rd, 32'd0);
      check_eq("alarm_o_burst", {28'b0, alarm_o}, 32'h1);

      // Software and external clears
      wb_write(A_LATCH, 32'h1);
      wb_read(A_LATCH, rd); check_eq("latch_w1c", rd, 32'h0);
      wb_write(A_CNT0, 32'h0);
      wb_read(A_CNT0, rd);  check_eq("cnt0_clr", rd, 32'd0);
      glitch(2);
      repeat (5) tick();
      wb_read(A_CNT2, rd);  check_eq("cnt2_one", rd, 32'd1);
      ext_ctr_clr = 1'b1;
      tick();
      ext_ctr_clr = 1'b0;
      repeat (3) tick();
      wb_read(A_CNT2, rd);  check_eq("ext_ctr_clr", rd, 32'd0);

      // Saturation, then wrap with overflow
      for (int i = 0; i < 300; i++) begin glitch(1); repeat (3) tick(); end
      repeat (4) tick();
      wb_read(A_CNT1, rd);  check_eq("cnt1_sat", rd, 32'd255);
      wb_read(A_OVF, rd);   check_eq("ovf_sat", rd, 32'h0);
      wb_write(A_CNT1, 32'h0);
      wb_write(A_CTRL, 32'hB);
      for (int i = 0; i < 300; i++) begin glitch(1); repeat (3) tick(); end
      repeat (4) tick();
      wb_read(A_CNT1, rd);  check_eq("cnt1_wrap", rd, 32'd44);
      wb_read(A_OVF, rd);   check_eq("ovf_wrap", rd, 32'h2);
      wb_write(A_OVF, 32'h2);
      wb_read(A_OVF, rd);   check_eq("ovf_w1c", rd, 32'h0);

      // Interrupt masking
      wb_write(A_LATCH, 32'hF);
      wb_write(A_MASK, 32'h4);
      wb_read(A_MASK, rd);  check_eq("mask_rd", rd, 32'h4);
      wb_write(A_CTRL, 32'h7);
      glitch(3);
      repeat (5) tick();
      check_eq("irq_masked", {31'b0, irq_o}, 32'd0);
      wb_read(A_LATCH, rd); check_eq("latch_ch3", rd, 32'h8);
      glitch(2);
      repeat (5) tick();
      check_eq("irq_set", {31'b0, irq_o}, 32'd1);
      wb_write(A_LATCH, 32'h4);
      check_eq("irq_hold", {31'b0, irq_o}, 32'd1);
      tick();
      check_eq("irq_clr", {31'b0, irq_o}, 32'd0);

      // Event coinciding with LATCH W1C, then with a CNT write
      wb_write(A_CTRL, 32'h3);
      glitch(0);
      repeat (2) tick();
      wb_write(A_LATCH, 32'h1);
      repeat (2) tick();
      wb_read(A_LATCH, rd); check_eq("evt_vs_w1c", rd, 32'h9);
      glitch(0);
      repeat (2) tick();
      wb_write(A_CNT0, 32'h0);
      repeat (2) tick();
      wb_read(A_CNT0, rd);  check_eq("evt_vs_cntclr", rd, 32'd1);

      // Reset in the middle of activity
      wb_write(A_CTRL, 32'h7);
      glitch(1);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = A_INFO;
      tick();
      check_eq("pre_rst_ack", {31'b0, o_wb_ack}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_ack", {31'b0, o_wb_ack}, 32'd0);
      check_eq("mid_rst_data", o_wb_data, 32'd0);
      check_eq("mid_rst_alarm", {28'b0, alarm_o}, 32'd0);
      check_eq("mid_rst_async", {28'b0, alarm_async_o}, 32'd0);
      check_eq("mid_rst_vcc", {31'b0, hp_vcc_o}, 32'd0);
      check_eq("mid_rst_irq", {31'b0, irq_o}, 32'd0);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      wb_read(A_CNT0, rd);  check_eq("post_rst_cnt0", rd, 32'd0);
      wb_read(A_CTRL, rd);  check_eq("post_rst_ctrl", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
